// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a per-grant hold limit.
// Grants are registered; a forced release at MAX_HOLD pulses timeout for one cycle.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [2:0]        win;
  logic              found;
  logic [2:0]        cand;

  // First requester after the last winner, wrapping back to the last winner itself.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd7;
      hold_cnt    <= '0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            state       <= GRANT;
            ptr         <= win;
            hold_cnt    <= '0;
            grant       <= 8'b1 << win;
            grant_idx   <= win;
            grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          // A dropped request wins over the hold limit, so no timeout on that cycle.
          if (!en || !req[grant_idx]) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit, arbitration enable; low suspends and revokes grants.
REQ-005 The block SHALL have port req, input, 8 bits, one request line per requester, level-sensitive.
REQ-006 The block SHALL have port grant, output, 8 bits, registered one-hot grant (bit i = requester i), or all-zero.
REQ-007 The block SHALL have port grant_idx, output, 3 bits, registered binary index of the current grantee; 0 when no grant.
REQ-008 The block SHALL have port grant_valid, output, 1 bit, high exactly when grant is non-zero.
REQ-009 The block SHALL have port timeout, output, 1 bit, one-cycle pulse marking a forced release at MAX_HOLD.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-011 The block SHALL keep a 3-bit last-winner pointer; search order SHALL be ptr+1, ptr+2, ... ptr+8, modulo 8.
REQ-012 In IDLE with en=1 and req!=0, the block SHALL select the first set req bit in search order, enter GRANT at the next edge, and load pointer with the winner index.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled high at edge N -> grant/grant_idx/grant_valid valid after edge N+1.
REQ-014 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with all outputs zero.
REQ-015 grant SHALL always equal the 3-to-8 one-hot decode of grant_idx when grant_valid=1, and be 8'h00 otherwise.
REQ-016 A hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
REQ-017 In GRANT, if req[grant_idx]=0 or en=0, the block SHALL return to IDLE at the next edge with no timeout pulse.
REQ-018 In GRANT, if the hold counter equals MAX_HOLD-1 and req[grant_idx]=1 and en=1, the block SHALL return to IDLE at the next edge and assert timeout for exactly that one following cycle.
REQ-019 A grant SHALL therefore last at most MAX_HOLD cycles, followed by at least one IDLE cycle before any new grant.
REQ-020 Requests arriving or changing on non-granted lines during GRANT SHALL NOT affect the current grant.
REQ-021 After release, a requester still requesting SHALL receive lowest priority in the next arbitration (fairness: any continuously asserted req is granted within 8 arbitrations).
REQ-022 Simultaneous release and timeout conditions (req drop on the MAX_HOLD-1 cycle) SHALL be treated as a normal release, with timeout=0.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously force state IDLE, grant=8'h00, grant_idx=0, grant_valid=0, timeout=0, hold counter=0, pointer=7 (so requester 0 has first priority).
REQ-024 Reset asserted mid-GRANT SHALL clear the grant immediately, without waiting for a clock edge; first arbitration after deassertion SHALL follow REQ-012.

Verification
REQ-025 Reset then req=8'h01 held -> grant=8'h01, grant_idx=0 one cycle later; released after MAX_HOLD=4 cycles with timeout pulse; one IDLE cycle; re-granted to 0.
REQ-026 req=8'hFF held, MAX_HOLD=4 -> grants in order 0,1,2,...,7,0, each 4 cycles, one IDLE gap between them, timeout pulsed on each release.
REQ-027 Grant to requester 3, drop req[3] after 2 cycles -> grant=0 next edge, timeout stays 0, then next set req above 3 wins.
REQ-028 en driven 0 during grant to requester 5 -> grant=8'h00 next edge; while en=0 and req=8'hFF, no grant; en=1 -> requester 6 granted after one cycle.
REQ-029 rst_n pulsed low mid-grant to requester 2 -> outputs zero asynchronously; after release with req=8'h0C, requester 2 granted (pointer back to 7).
REQ-030 Random req/en stimulus for 10k cycles -> checker confirms grant one-hot or zero, grant matches decode(grant_idx), grant only to requesting lines, no grant longer than MAX_HOLD.
